// File: rtl/vram_fill_dma.sv
`default_nettype none
// ============================================================================
//  Module   : vram_fill_dma
//  Purpose  : Bus initiator that writes one 16-bit pixel value into a run of
//             consecutive VRAM words through the SRAM controller video port.
//             Intended for screen clears and rectangle-row fills.
//  Ports    : clk_50mhz, rst_n (async, active-low)
//             cfg_start/cfg_abort pulses, cfg_base/cfg_len/cfg_color setup
//             busy, done (sticky), err (sticky timeout)
//             v_stb/v_we/v_addra/v_dina request, v_ACK ready/acknowledge
//  Options  : define VRAM_FILL_TIMEOUT_EN to abandon a beat whose ACK does not
//             arrive within TIMEOUT cycles (sets err and done).
//  Revision : 1.0 - initial release
// ============================================================================
module vram_fill_dma #(
    parameter int ACK_BLANK = 2,    // must be >= 1
    parameter int TIMEOUT   = 1023  // must be >= 1
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic        cfg_abort,
    input  logic [19:0] cfg_base,
    input  logic [19:0] cfg_len,
    input  logic [15:0] cfg_color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        v_stb,
    output logic        v_we,
    output logic [19:0] v_addra,
    output logic [47:0] v_dina,
    input  logic        v_ACK
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // One beat counter serves both the ACK blanking window and the timeout.
    localparam int                 c_cnt_w      = $clog2(ACK_BLANK + TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(ACK_BLANK - 1);

    logic [1:0]         r_state;
    logic [19:0]        r_addr;
    logic [19:0]        r_remain;
    logic [15:0]        r_color;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_abort_pend;
    logic               r_stb;
    logic               r_busy;
    logic               r_done;
    logic               w_tmo_fire;

`ifdef VRAM_FILL_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 1);

    logic r_err;

    // An ACK seen in WAIT on the last allowed cycle still completes the beat.
    assign w_tmo_fire = (r_cnt == c_tmo_last) &&
                        ((r_state == S_REQ) || ((r_state == S_WAIT) && !v_ACK));

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && cfg_start) begin
            r_err <= 1'b0;
        end else if (w_tmo_fire) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_tmo_fire = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_color      <= '0;
            r_cnt        <= '0;
            r_abort_pend <= 1'b0;
            r_stb        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_tmo_fire) begin
            // Abandon the fill; the address stays on the failed word.
            r_stb        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_abort_pend <= 1'b0;
            r_state      <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Abort in IDLE is ignored, including when it coincides
                    // with a start.
                    if (cfg_start) begin
                        if (cfg_len != 20'd0) begin
                            r_addr       <= cfg_base;
                            r_remain     <= cfg_len;
                            r_color      <= cfg_color;
                            r_cnt        <= '0;
                            r_abort_pend <= 1'b0;
                            r_done       <= 1'b0;
                            r_stb        <= 1'b1;
                            r_busy       <= 1'b1;
                            r_state      <= S_REQ;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    // The controller's ACK is still the idle-high level here,
                    // so it is not looked at until the blank window expires.
                    if (cfg_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_blank_last) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (cfg_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (v_ACK) begin
                        r_stb    <= 1'b0;
                        r_addr   <= r_addr + 20'd1;
                        r_remain <= r_remain - 20'd1;
                        r_state  <= S_GAP;
                    end else begin
`ifdef VRAM_FILL_TIMEOUT_EN
                        r_cnt <= r_cnt + c_cnt_one;
`endif
                    end
                end

                S_GAP: begin
                    // One strobe-low cycle lets the controller's sequencer idle.
                    if ((r_remain == 20'd0) || r_abort_pend || cfg_abort) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_abort_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt   <= '0;
                        r_stb   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end

                default: begin
                    r_stb   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign v_stb   = r_stb;
    assign v_we    = r_stb;
    assign v_addra = r_addr;
    assign v_dina  = {32'h0000_0000, r_color};

endmodule
`default_nettype wire

// File: doc/vram_fill_dma.md
# vram_fill_dma

Bus initiator that fills a run of VRAM words with one 16-bit pixel value through the SRAM controller's video port (`v_stb`/`v_we`/`v_addra`/`v_dina`/`v_ACK`). It offloads screen clears and rectangle-row fills from the CPU. It sits between a CPU-visible control register block and the video-side request port of the SRAM controller, and issues one single-word write per handshake.

## Interface
Parameters:
- `ACK_BLANK`, 2: cycles after `v_stb` rises during which `v_ACK` is ignored. The SRAM controller holds ACK high while idle and drops it one cycle after a write starts.
- `TIMEOUT`, 1023: maximum cycles spent in a single beat waiting for ACK. Used only under `VRAM_FILL_TIMEOUT_EN`.

Ports:
- `clk_50mhz` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_start` in 1: one-cycle start pulse.
- `cfg_abort` in 1: one-cycle abort request.
- `cfg_base` in 20: first VRAM word address.
- `cfg_len` in 20: number of words to write.
- `cfg_color` in 16: pixel value.
- `busy` out 1: fill in progress.
- `done` out 1: sticky; set when a fill completes or is aborted; cleared by the next accepted `cfg_start`.
- `err` out 1: sticky timeout flag; cleared by the next accepted `cfg_start`.
- `v_stb` out 1: request strobe.
- `v_we` out 1: write enable; equals `v_stb`.
- `v_addra` out 20: word address.
- `v_dina` out 48: write data, `{32'h0, color}`. The controller places bits [15:0] into the VRAM half.
- `v_ACK` in 1: controller ready/acknowledge (level).

## Operation
- States: IDLE, REQ, WAIT, GAP.
- **IDLE**
  - Outputs: `v_stb`=0, `busy`=0.
  - `cfg_start` with `cfg_len`≠0: latch base, len, and color; clear `done` and `err`; go to REQ.
  - `cfg_start` with `cfg_len`=0: clear `err`, set `done`, stay in IDLE.
- **REQ**
  - Outputs: `v_stb`=`v_we`=1, `v_addra`=current address.
  - A blank counter runs for `ACK_BLANK` cycles, then the FSM goes to WAIT.
- **WAIT**
  - `v_stb` stays 1.
  - First sampled `v_ACK`=1 completes the beat; go to GAP.
- **GAP**
  - `v_stb`=0 for exactly one cycle, so the controller's write sequencer returns to its idle state.
  - Address increments by 1, modulo 2^20 (0xFFFFF wraps to 0x00000). Remaining count decrements.
  - Remaining = 0, or an abort is pending: go to IDLE and set `done`. Otherwise go to REQ.
- `cfg_start` while `busy` is ignored; latched values do not change.
- `cfg_abort` while busy sets a pending flag. The current beat always completes, and the abort is honored at the next GAP. `cfg_abort` in IDLE has no effect.
- `cfg_start` and `cfg_abort` in the same IDLE cycle: start wins and the abort is discarded.
- `v_addra` and `v_dina` are held stable for the whole REQ+WAIT interval of a beat.

## Timing
- Reset values: state IDLE, `v_stb`=0, `v_we`=0, `v_addra`=0, `v_dina`=0, `busy`=0, `done`=0, `err`=0, counters 0.
- Reset asserted mid-fill: `v_stb` drops asynchronously. No resume after reset; the partial fill is left as written.
- `cfg_start` sampled at edge N: `v_stb`=1 and `busy`=1 from N+1.
- Beat cost: `ACK_BLANK` + w + 1 cycles, where w is the number of WAIT cycles (w ≥ 1).
- `done` rises in the cycle after the final GAP. `busy` falls in the same cycle.
- All outputs are registered.

## Configuration
- `VRAM_FILL_TIMEOUT_EN` defined:
  - A per-beat counter runs through REQ+WAIT.
  - If it reaches `TIMEOUT` without ACK: drop `v_stb`, go straight to IDLE, set `err`=1 and `done`=1, and leave the address un-incremented.
- `VRAM_FILL_TIMEOUT_EN` undefined:
  - No counter. WAIT lasts indefinitely and `err` is tied to 0.

## Test plan
- **Basic fill:** base=0x00100, len=4, color=0xF81F, controller model whose ACK drops 1 cycle after `v_stb` and recovers 4 cycles later -> exactly 4 writes to 0x100–0x103 with `v_dina`=0x0000_0000_F81F; one `v_stb`-low cycle between beats; `done`=1, `busy`=0 afterward.
- **Zero length:** len=0 -> no `v_stb` pulse; `done`=1 on the next cycle.
- **Address wrap:** base=0xFFFFE, len=3 -> writes to 0xFFFFE, 0xFFFFF, 0x00000.
- **Abort mid-beat:** len=100, pulse `cfg_abort` during WAIT of the 3rd beat -> the 3rd write completes, there is no 4th `v_stb`, and `done`=1.
- **Restart and reset:** start while busy -> ignored, original len honored. Assert `rst_n` low during WAIT -> `v_stb`=0 immediately and all flags 0.
- **Timeout (`VRAM_FILL_TIMEOUT_EN`, `TIMEOUT`=16):** ACK held low forever -> `v_stb` drops after 16 cycles, `err`=1, `done`=1, `busy`=0.
